// File: rtl/sam_mouse_ps2_if.sv
`default_nettype none
// ============================================================================
// Module   : sam_mouse_ps2_if
// Brief    : CPU read-side bundle: mouse port select and returned nibble.
// Revision : 1.0  initial release
// ============================================================================
interface sam_mouse_ps2_if;
    logic       rdmsel;
    logic [3:0] mdata;

    modport master (output rdmsel, input  mdata);
    modport slave  (input  rdmsel, output mdata);
endinterface
`default_nettype wire

// File: rtl/sam_mouse_ps2.sv
`default_nettype none
// ============================================================================
// Module   : sam_mouse_ps2
// Brief    : PS/2 mouse receiver, X/Y accumulator and SAM Coupe nibble stream.
//            Define SAM_MOUSE_INIT_EN to enable the host-side init (0xF4) FSM.
// Revision : 1.0  initial release
// ============================================================================
module sam_mouse_ps2 #(
    parameter int FILTER_LEN      = 8,
    parameter int TIMEOUT_CYCLES  = 600,
    parameter int FRAME_TO_CYCLES = 24000,
    parameter int INHIBIT_CYCLES  = 1200
) (
    input  wire logic      clk,
    input  wire logic      rst,
    inout  wire            clkps2,
    inout  wire            dataps2,
    sam_mouse_ps2_if.slave cpu
);
    localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_FTO_W  = $clog2(FRAME_TO_CYCLES + 1);

    logic w_run;
    logic w_rx_en;

    // ------------------------------------------------------------------
    // Line synchronisers and clock glitch filter
    // ------------------------------------------------------------------
    logic                r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic                r_clk_filt, r_fall;
    logic [c_FILT_W-1:0] r_filt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1 <= clkps2;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= dataps2;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
                r_fall     <= r_clk_filt;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // 11-bit frame receiver
    // ------------------------------------------------------------------
    logic [3:0]         r_bit_cnt;
    logic [9:0]         r_shift;
    logic [c_FTO_W-1:0] r_frame_to;
    logic               r_rx_valid, r_rx_err;
    logic [7:0]         r_rx_byte;
    logic [10:0]        w_frame;
    logic               w_frame_ok;

    // w_frame[0] is the start bit, [10] the stop bit
    assign w_frame    = {r_dat_s2, r_shift};
    assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_frame_to <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            r_rx_byte  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            if (!w_rx_en) begin
                r_bit_cnt  <= '0;
                r_frame_to <= '0;
            end else if (r_fall) begin
                r_frame_to <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt  <= '0;
                    r_rx_byte  <= w_frame[8:1];
                    r_rx_valid <= w_frame_ok;
                    r_rx_err   <= ~w_frame_ok;
                end else begin
                    r_shift   <= {r_dat_s2, r_shift[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_frame_to == c_FTO_W'(FRAME_TO_CYCLES - 1)) begin
                    r_bit_cnt  <= '0;
                    r_frame_to <= '0;
                end else begin
                    r_frame_to <= r_frame_to + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet assembly, accumulation and CPU nibble stream
    // ------------------------------------------------------------------
    logic [1:0]         r_pkt_idx;
    logic               r_x_ovf, r_y_ovf, r_x_sign, r_y_sign;
    logic [2:0]         r_btn_pend, r_btn;
    logic [7:0]         r_b1;
    logic signed [11:0] r_acc_x, r_acc_y, r_lat_x, r_lat_y;
    logic               r_rdm_d;
    logic [3:0]         r_idx;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic               w_pkt_done, w_snap, w_rdm_fall, w_rdm_edge;
    logic signed [12:0] w_dx, w_dy;
    logic signed [11:0] w_base_x, w_base_y;
    logic [3:0]         w_mdata;

    function automatic logic signed [11:0] f_sat_add(input logic signed [11:0] a,
                                                     input logic signed [12:0] d);
        logic signed [13:0] s;
        s = {{2{a[11]}}, a} + {d[12], d};
        if (s > 14'sd2047)       return 12'sh7FF;
        else if (s < -14'sd2048) return 12'sh800;
        else                     return s[11:0];
    endfunction

    assign w_pkt_done = w_run & r_rx_valid & (r_pkt_idx == 2'd2);
    assign w_dx       = r_x_ovf ? 13'sd0 : {{4{r_x_sign}}, r_x_sign, r_b1};
    assign w_dy       = r_y_ovf ? 13'sd0 : {{4{r_y_sign}}, r_y_sign, r_rx_byte};
    assign w_rdm_fall = r_rdm_d & ~cpu.rdmsel;
    assign w_rdm_edge = r_rdm_d ^ cpu.rdmsel;
    assign w_snap     = w_rdm_fall & (r_idx == 4'd0);
    // A packet landing on the snapshot cycle starts the fresh accumulation
    assign w_base_x   = w_snap ? 12'sd0 : r_acc_x;
    assign w_base_y   = w_snap ? 12'sd0 : r_acc_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_idx  <= '0;
            r_x_ovf    <= 1'b0;
            r_y_ovf    <= 1'b0;
            r_x_sign   <= 1'b0;
            r_y_sign   <= 1'b0;
            r_btn_pend <= '0;
            r_btn      <= '0;
            r_b1       <= '0;
            r_acc_x    <= '0;
            r_acc_y    <= '0;
            r_lat_x    <= '0;
            r_lat_y    <= '0;
        end else begin
            if (!w_run || r_rx_err) begin
                r_pkt_idx <= '0;
            end else if (r_rx_valid) begin
                case (r_pkt_idx)
                    2'd0: if (r_rx_byte[3]) begin
                        {r_y_ovf, r_x_ovf, r_y_sign, r_x_sign} <= r_rx_byte[7:4];
                        r_btn_pend <= r_rx_byte[2:0];
                        r_pkt_idx  <= 2'd1;
                    end
                    2'd1: begin
                        r_b1      <= r_rx_byte;
                        r_pkt_idx <= 2'd2;
                    end
                    default: r_pkt_idx <= 2'd0;
                endcase
            end

            if (w_snap) begin
                r_lat_x <= r_acc_x;
                r_lat_y <= r_acc_y;
            end
            if (w_pkt_done) begin
                r_acc_x <= f_sat_add(w_base_x, w_dx);
                r_acc_y <= f_sat_add(w_base_y, w_dy);
                r_btn   <= r_btn_pend;
            end else if (w_snap) begin
                r_acc_x <= '0;
                r_acc_y <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdm_d  <= 1'b0;
            r_idx    <= '0;
            r_to_cnt <= '0;
        end else begin
            r_rdm_d <= cpu.rdmsel;
            if (w_rdm_edge) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_TO_W'(TIMEOUT_CYCLES - 1)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_rdm_fall) begin
                r_idx <= (r_idx == 4'd8) ? 4'd0 : r_idx + 4'd1;
            end else if (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
                r_idx <= 4'd0;
            end
        end
    end

    always_comb begin
        w_mdata = 4'hF;
        case (r_idx)
            4'd1:    w_mdata = {1'b1, ~r_btn};
            4'd2:    w_mdata = r_lat_y[11:8];
            4'd3:    w_mdata = r_lat_y[7:4];
            4'd4:    w_mdata = r_lat_y[3:0];
            4'd5:    w_mdata = r_lat_x[11:8];
            4'd6:    w_mdata = r_lat_x[7:4];
            4'd7:    w_mdata = r_lat_x[3:0];
            default: w_mdata = 4'hF;
        endcase
    end

    assign cpu.mdata = w_mdata;

`ifdef SAM_MOUSE_INIT_EN
    // ------------------------------------------------------------------
    // Host init: inhibit, request-to-send, transmit 0xF4, await 0xFA
    // ------------------------------------------------------------------
    localparam int         c_INH_W   = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [8:0] c_TX_BITS = {~^8'hF4, 8'hF4};

    typedef enum logic [2:0] {
        ST_INHIBIT = 3'd0,
        ST_REQ     = 3'd1,
        ST_TX      = 3'd2,
        ST_ACKBIT  = 3'd3,
        ST_WAITFA  = 3'd4,
        ST_RUN     = 3'd5
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_INH_W-1:0] r_inh_cnt;
    logic [19:0]        r_wait_cnt;
    logic [3:0]         r_tx_cnt;
    logic               r_clk_low, r_dat_low;
    logic               w_clk_low, w_dat_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INHIBIT;
            r_inh_cnt  <= '0;
            r_wait_cnt <= '0;
            r_tx_cnt   <= '0;
            r_clk_low  <= 1'b0;
            r_dat_low  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_low  <= w_clk_low;
            r_dat_low  <= w_dat_low;
            r_inh_cnt  <= (r_state == ST_INHIBIT) ? r_inh_cnt + 1'b1 : '0;
            r_wait_cnt <= (r_state == ST_WAITFA) ? r_wait_cnt + 20'd1 : '0;
            if (r_state != ST_TX)
                r_tx_cnt <= '0;
            else if (r_fall)
                r_tx_cnt <= r_tx_cnt + 4'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clk_low   = 1'b0;
        w_dat_low   = 1'b0;
        case (r_state)
            ST_INHIBIT: begin
                w_clk_low = 1'b1;
                if (r_inh_cnt == c_INH_W'(INHIBIT_CYCLES - 1))
                    w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_dat_low = 1'b1;
                if (r_fall)
                    w_state_nxt = ST_TX;
            end
            ST_TX: begin
                w_dat_low = ~c_TX_BITS[r_tx_cnt];
                if (r_fall && r_tx_cnt == 4'd8)
                    w_state_nxt = ST_ACKBIT;
            end
            ST_ACKBIT: begin
                if (r_fall)
                    w_state_nxt = r_dat_s2 ? ST_INHIBIT : ST_WAITFA;
            end
            ST_WAITFA: begin
                if (r_rx_valid)
                    w_state_nxt = (r_rx_byte == 8'hFA) ? ST_RUN : ST_INHIBIT;
                else if (r_rx_err || (&r_wait_cnt))
                    w_state_nxt = ST_INHIBIT;
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INHIBIT;
        endcase
    end

    assign w_run   = (r_state == ST_RUN);
    assign w_rx_en = (r_state == ST_RUN) || (r_state == ST_WAITFA);
    assign clkps2  = r_clk_low ? 1'b0 : 1'bz;
    assign dataps2 = r_dat_low ? 1'b0 : 1'bz;
`else
    assign w_run   = 1'b1;
    assign w_rx_en = 1'b1;
    assign clkps2  = 1'bz;
    assign dataps2 = 1'bz;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sam_mouse_ps2.sv
`default_nettype none
// ============================================================================
// Module   : tb_sam_mouse_ps2
// Brief    : Self-checking bench: PS/2 device model driving packets, CPU
//            nibble reads compared against a saturating-accumulator model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sam_mouse_ps2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    wire  clkps2;
    wire  dataps2;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         acc_x = 0, acc_y = 0, lat_x = 0, lat_y = 0;
    logic [2:0] btn = 3'b000;
    logic [7:0] rb0, rb1, rb2;
    logic [9:0] host_bits;
    logic [3:0] nib;

    sam_mouse_ps2_if bus ();

    assign clkps2  = dev_clk_low ? 1'b0 : 1'bz;
    assign dataps2 = dev_dat_low ? 1'b0 : 1'bz;
    pullup (clkps2);
    pullup (dataps2);

    sam_mouse_ps2 dut (
        .clk     (clk),
        .rst     (rst),
        .clkps2  (clkps2),
        .dataps2 (dataps2),
        .cpu     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Device-side frame: bit 0 first; nbits < 11 leaves a truncated frame
    task automatic ps2_frame(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dev_dat_low = ~f[i];
            repeat (6) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (14) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (6) @(negedge clk);
        end
        dev_dat_low = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic ps2_send(input logic [7:0] b, input bit bad_par);
        ps2_frame({1'b1, (~^b) ^ bad_par, b, 1'b0}, 11);
    endtask

    function automatic int sat(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int delta(input logic sgn, input logic [7:0] b);
        return sgn ? int'(b) - 256 : int'(b);
    endfunction

    // Valid packet: transmit, then apply to the model
    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        ps2_send(b0, 1'b0);
        ps2_send(b1, 1'b0);
        ps2_send(b2, 1'b0);
        if (!b0[6]) acc_x = sat(acc_x + delta(b0[4], b1));
        if (!b0[7]) acc_y = sat(acc_y + delta(b0[5], b2));
        btn = b0[2:0];
    endtask

    function automatic logic [3:0] exp_nib(input int idx);
        logic [11:0] ex, ey;
        ex = 12'(lat_x);
        ey = 12'(lat_y);
        case (idx)
            1:       return {1'b1, ~btn};
            2:       return ey[11:8];
            3:       return ey[7:4];
            4:       return ey[3:0];
            5:       return ex[11:8];
            6:       return ex[7:4];
            7:       return ex[3:0];
            default: return 4'hF;
        endcase
    endfunction

    task automatic model_snap();
        lat_x = acc_x;
        lat_y = acc_y;
        acc_x = 0;
        acc_y = 0;
    endtask

    task automatic read_nib(output logic [3:0] n);
        bus.rdmsel = 1'b1;
        repeat (3) @(negedge clk);
        n = bus.mdata;
        bus.rdmsel = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        logic [3:0] n;
        model_snap();
        for (int i = 0; i < 9; i++) begin
            read_nib(n);
            check($sformatf("%s idx%0d", tag, i), {12'd0, n}, {12'd0, exp_nib(i)});
        end
    endtask

    initial begin
        bus.rdmsel = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset mdata", {12'd0, bus.mdata}, 16'h000F);

`ifdef SAM_MOUSE_INIT_EN
        repeat (100) @(negedge clk);
        check("inhibit early", {15'd0, clkps2}, 16'd0);
        repeat (1000) @(negedge clk);
        check("inhibit late", {15'd0, clkps2}, 16'd0);
        for (int i = 0; i < 400 && clkps2 !== 1'b1; i++) @(negedge clk);
        check("inhibit release", {15'd0, clkps2}, 16'd1);
        @(negedge clk);
        check("request data low", {15'd0, dataps2}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (8) @(negedge clk);
            host_bits[i] = dataps2;
            repeat (12) @(negedge clk);
        end
        check("host tx F4 frame", {6'd0, host_bits}, 16'h02F4);
        dev_dat_low = 1'b1;
        repeat (6) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (6) @(negedge clk);
        dev_dat_low = 1'b0;
        repeat (20) @(negedge clk);
        ps2_send(8'hFA, 1'b0);
        repeat (700) @(negedge clk);
`endif
        check("clkps2 released", {15'd0, clkps2}, 16'd1);
        check("dataps2 released", {15'd0, dataps2}, 16'd1);

        send_packet(8'h08, 8'h05, 8'h03);
        check_stream("basic");

        send_packet(8'h19, 8'hFE, 8'h00);
        check_stream("negx");
        check_stream("cleared");

        ps2_send(8'h08, 1'b1);
        send_packet(8'h08, 8'h01, 8'h01);
        check_stream("badpar");
        ps2_send(8'h00, 1'b0);
        send_packet(8'h0A, 8'h02, 8'h03);
        check_stream("resync");

        ps2_frame(11'b111_0000_1000, 4);
        repeat (24100) @(negedge clk);
        send_packet(8'h08, 8'h03, 8'h04);
        check_stream("frame timeout");

        send_packet(8'h08, 8'h00, 8'h20);
        model_snap();
        for (int i = 0; i < 3; i++) begin
            read_nib(nib);
            check($sformatf("partial idx%0d", i), {12'd0, nib}, {12'd0, exp_nib(i)});
        end
        repeat (700) @(negedge clk);
        model_snap();
        read_nib(nib);
        check("idx timeout", {12'd0, nib}, 16'h000F);
        repeat (700) @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            for (int k = $urandom_range(1, 3); k > 0; k--) begin
                rb0 = 8'($urandom);
                rb0[3] = 1'b1;
                rb0[6] = ($urandom_range(0, 7) == 0);
                rb0[7] = ($urandom_range(0, 7) == 0);
                rb1 = 8'($urandom);
                rb2 = 8'($urandom);
                send_packet(rb0, rb1, rb2);
            end
            check_stream($sformatf("random%0d", r));
        end

        for (int i = 0; i < 17; i++) send_packet(8'h08, 8'h7F, 8'h00);
        check_stream("sat pos");
        send_packet(8'h48, 8'h10, 8'h05);
        check_stream("x ovf");
        for (int i = 0; i < 17; i++) send_packet(8'h38, 8'h80, 8'h80);
        send_packet(8'h08, 8'h05, 8'h01);
        check_stream("sat neg");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
